// File: rtl/dh_exchange_ctrl.sv
// Diffie-Hellman exchange sequencer: LFSR keygen, public key via mod-exp unit, link swap, shared secret.
// Optional RX_WAIT timeout is compiled in with `define DH_RX_TIMEOUT_EN.
module dh_exchange_ctrl #(
    parameter int             N       = 8,
    parameter int             P       = 89,
    parameter int             G       = 3,
    parameter logic [N-1:0]   TAPS    = 8'hB8,
    parameter int             TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic [N-1:0] seed,
    output logic         mp_start,
    output logic [N-1:0] mp_base,
    output logic [N-1:0] mp_exp,
    input  logic [N-1:0] mp_res,
    input  logic         mp_rdy,
    output logic [N-1:0] tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [N-1:0] rx_data,
    input  logic         rx_valid,
    output logic [N-1:0] shared_key,
    output logic         key_valid,
    output logic         busy,
    output logic [1:0]   err_code
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] KEYGEN    = 4'd1;
    localparam logic [3:0] PUB_START = 4'd2;
    localparam logic [3:0] PUB_WAIT  = 4'd3;
    localparam logic [3:0] TX        = 4'd4;
    localparam logic [3:0] RX_WAIT   = 4'd5;
    localparam logic [3:0] SEC_START = 4'd6;
    localparam logic [3:0] SEC_WAIT  = 4'd7;
    localparam logic [3:0] DONE      = 4'd8;
    localparam logic [3:0] ERR       = 4'd9;

    localparam logic [N-1:0] ONE_N    = N'(1);
    localparam logic [N-1:0] TWO_N    = N'(2);
    localparam logic [N-1:0] G_N      = N'(G);
    localparam logic [N-1:0] PMINUS2  = N'(P - 2);

    if (P < 3 || P >= (1 << N) || G <= 1 || G >= P || TIMEOUT < 1) begin : g_param_check
        $error("dh_exchange_ctrl: illegal parameter set");
    end

    logic [3:0]   state;
    logic [N-1:0] lfsr;
    logic [N-1:0] lfsr_next;
    logic [N-1:0] priv;
    logic [N-1:0] peer;
    logic         peer_full;
    logic         active;
    logic         lfsr_ok;
    logic         peer_ok;

`ifdef DH_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] rx_cnt;
`endif

    always_comb begin
        lfsr_next = {1'b0, lfsr[N-1:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
    end

    assign active  = (state != IDLE) && (state != DONE) && (state != ERR);
    assign lfsr_ok = (lfsr >= ONE_N) && (lfsr <= PMINUS2);
    // Range check alone rejects 0, 1, P-1 and anything >= P.
    assign peer_ok = (peer >= TWO_N) && (peer <= PMINUS2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= ONE_N;
            priv       <= '0;
            peer       <= '0;
            peer_full  <= 1'b0;
            mp_start   <= 1'b0;
            mp_base    <= '0;
            mp_exp     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            shared_key <= '0;
            key_valid  <= 1'b0;
            busy       <= 1'b0;
            err_code   <= 2'd0;
`ifdef DH_RX_TIMEOUT_EN
            rx_cnt     <= '0;
`endif
        end else if (ena) begin
            // First peer key wins; it may arrive any time the exchange is running.
            if (active && rx_valid && !peer_full) begin
                peer      <= rx_data;
                peer_full <= 1'b1;
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        lfsr      <= (seed == '0) ? ONE_N : seed;
                        key_valid <= 1'b0;
                        err_code  <= 2'd0;
                        peer_full <= 1'b0;
                        busy      <= 1'b1;
                        state     <= KEYGEN;
                    end
                end
                KEYGEN: begin
                    if (lfsr_ok) begin
                        priv     <= lfsr;
                        mp_start <= 1'b1;
                        mp_base  <= G_N;
                        mp_exp   <= lfsr;
                        state    <= PUB_START;
                    end else begin
                        lfsr <= lfsr_next;
                    end
                end
                PUB_START: begin
                    mp_start <= 1'b0;
                    state    <= PUB_WAIT;
                end
                PUB_WAIT: begin
                    if (mp_rdy) begin
                        tx_data  <= mp_res;
                        tx_valid <= 1'b1;
                        state    <= TX;
                    end
                end
                TX: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= RX_WAIT;
`ifdef DH_RX_TIMEOUT_EN
                        rx_cnt   <= '0;
`endif
                    end
                end
                RX_WAIT: begin
                    if (peer_full) begin
                        if (peer_ok) begin
                            mp_start <= 1'b1;
                            mp_base  <= peer;
                            mp_exp   <= priv;
                            state    <= SEC_START;
                        end else begin
                            err_code <= 2'd1;
                            busy     <= 1'b0;
                            state    <= ERR;
                        end
                    end
`ifdef DH_RX_TIMEOUT_EN
                    else if (rx_cnt == TLAST) begin
                        err_code <= 2'd2;
                        busy     <= 1'b0;
                        state    <= ERR;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
`endif
                end
                SEC_START: begin
                    mp_start <= 1'b0;
                    state    <= SEC_WAIT;
                end
                SEC_WAIT: begin
                    if (mp_rdy) begin
                        shared_key <= mp_res;
                        key_valid  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// Directed bench for dh_exchange_ctrl with a behavioural mod-exp responder (P=89, G=3).
module tb_dh_exchange_ctrl;

    localparam int PM = 89;

    logic       clk, rst, ena, start;
    logic [7:0] seed;
    logic       mp_start;
    logic [7:0] mp_base, mp_exp, mp_res;
    logic       mp_rdy;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] shared_key;
    logic       key_valid, busy;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;
    bit tog = 0;

    dh_exchange_ctrl #(.N(8), .P(89), .G(3), .TAPS(8'hB8), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .seed(seed),
        .mp_start(mp_start), .mp_base(mp_base), .mp_exp(mp_exp),
        .mp_res(mp_res), .mp_rdy(mp_rdy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .shared_key(shared_key), .key_valid(key_valid), .busy(busy), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modexp(input int b, input logic [7:0] e);
        int r = 1;
        for (int i = 7; i >= 0; i--) begin
            r = (r * r) % PM;
            if (e[i]) r = (r * (b % PM)) % PM;
        end
        return r;
    endfunction

    // Behavioural exponentiation unit: fixed latency, shares rst and ena.
    logic [7:0] lb, le;
    logic       m_busy;
    int         m_cnt, starts, hold_viol;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mp_rdy <= 1'b0; mp_res <= '0; m_busy <= 1'b0; m_cnt <= 0;
            starts <= 0; hold_viol <= 0; lb <= '0; le <= '0;
        end else if (ena) begin
            mp_rdy <= 1'b0;
            if (m_busy) begin
                if (mp_base != lb || mp_exp != le) hold_viol <= hold_viol + 1;
                if (m_cnt <= 1) begin
                    mp_rdy <= 1'b1;
                    mp_res <= 8'(modexp(int'(lb), le));
                    m_busy <= 1'b0;
                end else m_cnt <= m_cnt - 1;
            end
            if (mp_start) begin
                starts <= starts + 1;
                lb <= mp_base; le <= mp_exp; m_busy <= 1'b1; m_cnt <= 4;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        if (tog) ena = ~ena;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] s);
        seed = s; start = 1'b1;
        step();
        if (tog) step();
        start = 1'b0;
    endtask

    task automatic to_mpstart(output int n);
        n = 0;
        while (!mp_start && n < 600) begin step(); n++; end
        check("mp_start_seen", 32'(mp_start), 1);
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_valid && n < 400) begin step(); n++; end
        check("tx_valid_seen", 32'(tx_valid), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin step(); n++; end
        check("busy_cleared", 32'(busy), 0);
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        step();
        if (tog) step();
        rx_valid = 1'b0;
    endtask

    logic [7:0] inv_seed [4] = '{8'd200, 8'd0, 8'd5, 8'd5};
    logic [7:0] inv_peer [4] = '{8'd1, 8'd88, 8'd0, 8'd200};
    int         inv_priv [4] = '{50, 1, 5, 5};
    int         inv_tx   [4] = '{72, 3, 65, 65};
    int         inv_kg   [4] = '{3, 1, 1, 1};

    initial begin
        int n, s0;
        bit ok;
        logic [7:0] d;
        rst = 1'b1; ena = 1'b1; start = 1'b0; seed = '0;
        tx_ready = 1'b1; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mp_start", 32'(mp_start), 0);
        check("rst_mp_base", 32'(mp_base), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_shared_key", 32'(shared_key), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err_code", 32'(err_code), 0);
        rst = 1'b0;
        step();

        // Nominal exchange, seed 5
        s0 = starts;
        do_start(8'd5);
        check("nom_busy", 32'(busy), 1);
        to_mpstart(n);
        check("nom_keygen_cycles", n, 1);
        check("nom_mp_base", 32'(mp_base), 3);
        check("nom_mp_exp", 32'(mp_exp), 5);
        wait_tx();
        check("nom_tx_data", 32'(tx_data), 65);
        step();
        check("nom_tx_valid_drop", 32'(tx_valid), 0);
        pulse_rx(8'd51);
        wait_idle();
        check("nom_key_valid", 32'(key_valid), 1);
        check("nom_shared_key", 32'(shared_key), 19);
        check("nom_mp_base_peer", 32'(mp_base), 51);
        check("nom_err_code", 32'(err_code), 0);
        check("nom_starts", starts - s0, 2);

        // LFSR rejection / seed 0 / invalid peer keys
        for (int i = 0; i < 4; i++) begin
            s0 = starts;
            do_start(inv_seed[i]);
            to_mpstart(n);
            check("inv_keygen_cycles", n, inv_kg[i]);
            wait_tx();
            check("inv_priv", 32'(mp_exp), inv_priv[i]);
            check("inv_tx_data", 32'(tx_data), inv_tx[i]);
            step();
            pulse_rx(inv_peer[i]);
            wait_idle();
            check("inv_err_code", 32'(err_code), 1);
            check("inv_key_valid", 32'(key_valid), 0);
            check("inv_starts", starts - s0, 1);
        end

        // Early peer key during PUB_WAIT, late one during TX is dropped
        s0 = starts;
        tx_ready = 1'b0;
        do_start(8'd5);
        check("early_err_cleared", 32'(err_code), 0);
        to_mpstart(n);
        step();
        pulse_rx(8'd51);
        wait_tx();
        check("early_tx_data", 32'(tx_data), 65);
        pulse_rx(8'd30);
        step();
        check("early_tx_hold", 32'(tx_valid), 1);
        tx_ready = 1'b1;
        wait_idle();
        check("early_shared_key", 32'(shared_key), 19);
        check("early_key_valid", 32'(key_valid), 1);
        check("early_starts", starts - s0, 2);

        // Enable toggling and tx stall
        s0 = starts;
        tog = 1'b1; tx_ready = 1'b0;
        do_start(8'd5);
        to_mpstart(n);
        ena = 1'b0;
        @(negedge clk);
        check("stall_mp_start_hold", 32'(mp_start), 1);
        check("stall_mp_base", 32'(mp_base), 3);
        wait_tx();
        d = tx_data; ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!tx_valid || tx_data !== d) ok = 1'b0;
        end
        check("stall_tx_stable", 32'(ok), 1);
        check("stall_tx_data", 32'(d), 65);
        do_start(8'd9);
        check("stall_start_ignored", 32'(tx_data), 65);
        check("stall_busy", 32'(busy), 1);
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 100) begin step(); n++; end
        check("stall_tx_drop", 32'(tx_valid), 0);
        pulse_rx(8'd51);
        wait_idle();
        check("stall_shared_key", 32'(shared_key), 19);
        check("stall_key_valid", 32'(key_valid), 1);
        check("stall_starts", starts - s0, 2);
        tog = 1'b0; ena = 1'b1;
        step();
        check("hold_violations", hold_viol, 0);

        // RX wait without a peer key
        do_start(8'd5);
        wait_tx();
        step();
`ifdef DH_RX_TIMEOUT_EN
        n = 0;
        while (err_code != 2'd2 && n < 300) begin step(); n++; end
        check("tmo_cycles", n, 100);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_key_valid", 32'(key_valid), 0);
`else
        repeat (10000) step();
        check("notmo_busy", 32'(busy), 1);
        check("notmo_err_code", 32'(err_code), 0);
        check("notmo_key_valid", 32'(key_valid), 0);
`endif

        // Asynchronous reset mid-operation
        do_start(8'd5);
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_mp_start", 32'(mp_start), 0);
        check("arst_err_code", 32'(err_code), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dh_exchange_ctrl.md
Name: dh_exchange_ctrl

Overview:
Sequencing controller for one Diffie-Hellman key exchange. It sits directly upstream of the modular exponentiation unit and drives its start/base/exp, then consumes its res/rdy. It generates a private exponent with an internal LFSR and computes the local public key G^priv mod P. It exchanges public keys with the radio link over a valid/ready transmit port and a strobe receive port, then computes the shared secret peer^priv mod P.

Parameters:
N, 8, operand width; must match the exponentiation unit.
P, 89, prime modulus; requires 3 <= P < 2^N.
G, 3, group generator; requires 1 < G < P.
TAPS, 8'hB8, Galois LFSR feedback mask (maximal length for N=8).
TIMEOUT, 1000, RX_WAIT limit in enabled cycles; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ena  in  1  clock enable; shared with the exponentiation unit
start  in  1  begin an exchange
seed  in  N  LFSR seed, sampled on start
mp_start  out  1  start pulse to the exponentiation unit
mp_base  out  N  base operand
mp_exp  out  N  exponent operand
mp_res  in  N  exponentiation result
mp_rdy  in  1  result-valid pulse from the exponentiation unit
tx_data  out  N  local public key
tx_valid  out  1  tx_data valid
tx_ready  in  1  link accepts tx_data
rx_data  in  N  peer public key
rx_valid  in  1  one-cycle strobe; rx_data valid
shared_key  out  N  shared secret
key_valid  out  1  shared_key valid
busy  out  1  exchange in progress
err_code  out  2  0 none, 1 invalid peer key, 2 rx timeout

Behaviour:
- All registers update only when ena=1. When ena=0 the block is fully frozen and inputs are not sampled.
- Reset values: state IDLE; every output 0; LFSR=1; priv=0; peer buffer empty.
- All outputs are registered. busy=1 in every state except IDLE, DONE and ERR.
- States: IDLE, KEYGEN, PUB_START, PUB_WAIT, TX, RX_WAIT, SEC_START, SEC_WAIT, DONE, ERR.
- IDLE/DONE/ERR + start:
  - load LFSR with seed (seed=0 loads 1)
  - clear key_valid, err_code and the peer buffer
  - go to KEYGEN
- start while busy is ignored.
- KEYGEN: if LFSR value is in [1, P-2], latch priv=LFSR and go to PUB_START. Otherwise step the LFSR and stay in KEYGEN.
  - Step rule: lsb=L[0]; L=L>>1; if lsb, L^=TAPS.
  - Termination is guaranteed within 2^N-1 cycles.
- PUB_START: mp_start=1 for exactly this one enabled cycle, with mp_base=G and mp_exp=priv. Go to PUB_WAIT.
- mp_base and mp_exp are held stable from the *_START state until mp_rdy.
- PUB_WAIT: on mp_rdy, latch tx_data=mp_res, set tx_valid=1 and go to TX.
- TX: tx_valid stays high and tx_data stays stable until tx_ready=1. On the cycle tx_ready=1, clear tx_valid and go to RX_WAIT.
- Peer buffer (one entry):
  - In any busy state, rx_valid with the buffer empty captures rx_data.
  - rx_valid with the buffer full is dropped; the first received key wins.
  - rx_valid in IDLE/DONE/ERR is ignored.
  - A key arriving before RX_WAIT is held and used.
- RX_WAIT: when the buffer is full, validate the peer key.
  - Valid range is 2 <= peer <= P-2; the range check rejects 0, 1, P-1 and values >= P.
  - Valid: go to SEC_START.
  - Invalid: err_code=1 and go to ERR. No second mp_start is issued.
- SEC_START: mp_start=1 for one cycle, with mp_base=peer and mp_exp=priv. Go to SEC_WAIT.
- SEC_WAIT: on mp_rdy, shared_key=mp_res, key_valid=1, go to DONE.
- DONE: key_valid and shared_key are held until the next start.
- ERR: err_code is held until the next start.
- mp_rdy outside PUB_WAIT/SEC_WAIT is ignored.
- Reset mid-operation returns the block to reset values on the asynchronous edge. The exponentiation unit shares rst, so no stale rdy follows.

Optional Feature:
- Macro: DH_RX_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RX_WAIT and increments every enabled cycle while RX_WAIT holds an empty buffer.
  - When the count reaches TIMEOUT: err_code=2 and go to ERR.
  - Counter width is clog2(TIMEOUT+1).
- Undefined: no counter; RX_WAIT waits indefinitely and err_code never equals 2.

Test Plan:
- Nominal exchange (P=89, G=3):
  - Stimulus: seed=5, tx_ready=1, rx_data=51 in RX_WAIT.
  - Response: priv=5, mp_exp=5, tx_data=65, then mp_base=51 and shared_key=19 with key_valid=1, err_code=0.
  - Exactly two mp_start pulses.
- LFSR rejection:
  - Stimulus: seed=200.
  - Response: the LFSR steps 200->100->50, so priv=50 after 2 KEYGEN step cycles, and tx_data=72.
  - seed=0: priv=1, tx_data=3.
- Early peer key and drop:
  - Stimulus: rx_valid with rx_data=51 during PUB_WAIT, then rx_data=30 during TX.
  - Response: the buffer keeps 51; with seed=5, shared_key=19.
- Invalid peer keys: each of rx_data=1, 88, 0 and 200 gives err_code=1, state ERR, key_valid=0, no second mp_start, busy=0. A following start restarts cleanly.
- Enable and handshake stall:
  - Stimulus: ena toggled 50% and tx_ready held low 20 cycles.
  - Response: tx_valid/tx_data stay stable, mp_start stays high until an enabled cycle, and the result matches the nominal case.
  - start while busy is ignored.
- Timeout (macro defined, TIMEOUT=100): with no rx_valid, err_code=2 exactly 100 enabled cycles after RX_WAIT entry. With the macro undefined, the block is still in RX_WAIT after 10000 cycles.
